alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_seq_datapath.sv | 45 ++++
 rtl/alu_sequencer.sv | 97 +++++++++
 tb/tb_alu_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and timing constants for the ALU sequencer and its datapath.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // Latencies are counted from the accepting edge; the operand register is the first stage.
    localparam int LAT_ADD = 2;
    localparam int LAT_SUB = 3;
    localparam int LAT_MUL = 2;
    localparam int CNT_W   = 2;

    function automatic logic [CNT_W-1:0] lat_of(input op_e op);
        case (op)
            OP_ADD:  return CNT_W'(LAT_ADD);
            OP_SUB:  return CNT_W'(LAT_SUB);
            OP_MUL:  return CNT_W'(LAT_MUL);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_datapath.sv
// Pipelined add/sub/mul units fed by the sequencer's held operand registers.
module alu_seq_datapath
    import alu_seq_pkg::*;
#(
    parameter int OPW = 17
) (
    input  logic             clk,
    input  op_e              op,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic [2*OPW-1:0] result
);
    localparam int RW = 2 * OPW;

    // Sign-extend to full width first so a-b stays exact even for b = -2^(OPW-1).
    logic signed [RW-1:0] a_w;
    logic signed [RW-1:0] b_w;
    assign a_w = {{OPW{a[OPW-1]}}, a};
    assign b_w = {{OPW{b[OPW-1]}}, b};

    logic [RW-1:0] add_pipe [LAT_ADD-1];
    logic [RW-1:0] sub_pipe [LAT_SUB-1];
    logic [RW-1:0] mul_pipe [LAT_MUL-1];

    // NOTE: pipeline data registers carry no reset; the sequencer only samples them once valid.
    always_ff @(posedge clk) begin
        add_pipe[0] <= a_w + b_w;
        sub_pipe[0] <= a_w - b_w;
        mul_pipe[0] <= a_w * b_w;
        for (int i = 1; i < LAT_ADD - 1; i++) add_pipe[i] <= add_pipe[i-1];
        for (int i = 1; i < LAT_SUB - 1; i++) sub_pipe[i] <= sub_pipe[i-1];
        for (int i = 1; i < LAT_MUL - 1; i++) mul_pipe[i] <= mul_pipe[i-1];
    end

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = add_pipe[LAT_ADD-2];
            OP_SUB:  result = sub_pipe[LAT_SUB-2];
            OP_MUL:  result = mul_pipe[LAT_MUL-2];
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Request/response sequencer: accepts one ALU op, waits out the unit latency,
// and holds the response until the consumer takes it.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int OPW = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [OPW-1:0]   req_a,
    input  logic [OPW-1:0]   req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2*OPW-1:0] rsp_result,
    output logic             rsp_err,
    output logic             busy,
    output logic [15:0]      op_count
);
    state_e           state;
    state_e           state_nxt;
    op_e              op_q;
    logic [OPW-1:0]   a_q;
    logic [OPW-1:0]   b_q;
    logic [CNT_W-1:0] cnt;
    logic [2*OPW-1:0] dp_result;
    logic             accept;
    logic             exec_last;
    logic             rsp_fire;
    logic             req_illegal;

    assign accept      = req_valid && req_ready;
    assign req_illegal = (op_e'(req_op) == OP_ILL);
    assign exec_last   = (cnt == CNT_W'(1));
    assign rsp_fire    = rsp_valid && rsp_ready;

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: default assignment first keeps this combinational block latch-free.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)    state_nxt = req_illegal ? S_DONE : S_EXEC;
            S_EXEC:  if (exec_last) state_nxt = S_DONE;
            S_DONE:  if (rsp_ready) state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == S_IDLE);
        rsp_valid = (state == S_DONE);
        busy      = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            cnt        <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                op_q       <= op_e'(req_op);
                a_q        <= req_a;
                b_q        <= req_b;
                cnt        <= lat_of(op_e'(req_op));
                rsp_err    <= req_illegal;
                rsp_result <= '0;
            end
            // The counter hits zero on the same edge that enters DONE and captures the unit output.
            if (state == S_EXEC) begin
                cnt <= cnt - CNT_W'(1);
                if (exec_last) rsp_result <= dp_result;
            end
            if (rsp_fire) op_count <= op_count + 16'd1;
        end
    end

    alu_seq_datapath #(.OPW(OPW)) u_datapath (
        .clk    (clk),
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (dp_result)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_alu_sequencer;
    localparam int OPW = 17;
    localparam int RW  = 2 * OPW;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [1:0]     req_op;
    logic [OPW-1:0] req_a;
    logic [OPW-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [RW-1:0]  rsp_result;
    logic           rsp_err;
    logic           busy;
    logic [15:0]    op_count;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.OPW(OPW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .op_count   (op_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact signed arithmetic on 64-bit integers, truncated to the result width.
    function automatic logic [RW-1:0] ref_result(input logic [1:0] op,
                                                 input logic [OPW-1:0] a,
                                                 input logic [OPW-1:0] b);
        longint sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'd0:    r = sa + sb;
            2'd1:    r = sa - sb;
            2'd2:    r = sa * sb;
            default: r = 0;
        endcase
        return r[RW-1:0];
    endfunction

    // Samples (one per cycle, first right after the accepting edge) until rsp_valid is seen.
    function automatic int ref_lat(input logic [1:0] op);
        case (op)
            2'd0:    return 2 + 1;
            2'd1:    return 3 + 1;
            2'd2:    return 2 + 1;
            default: return 1;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [OPW-1:0] a, input logic [OPW-1:0] b, input int hold);
        logic [RW-1:0] exp_res;
        logic          exp_err;
        int            n;
        exp_res = ref_result(op, a, b);
        exp_err = (op == 2'b11);
        check({tag, " ready"}, 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        tick();
        // Garbage on the request side while busy must be ignored.
        req_valid = 1'($urandom);
        req_op    = 2'($urandom);
        req_a     = OPW'($urandom);
        req_b     = OPW'($urandom);
        n = 1;
        while (!rsp_valid && n < 12) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(ref_lat(op)));
        check({tag, " rsp"}, 64'({rsp_err, rsp_result}), 64'({exp_err, exp_res}));
        check({tag, " excl"}, 64'({req_ready, busy}), 64'({1'b0, 1'b1}));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold"}, 64'({rsp_valid, rsp_err, req_ready, rsp_result}),
                  64'({1'b1, exp_err, 1'b0, exp_res}));
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        exp_count = (exp_count + 1) % 65536;
        check({tag, " done"}, 64'({req_ready, busy, rsp_valid, op_count}),
              64'({1'b1, 1'b0, 1'b0, 16'(exp_count)}));
    endtask

    initial begin
        int seen;
        logic [1:0]     r_op;
        logic [OPW-1:0] r_a;
        logic [OPW-1:0] r_b;
        logic [OPW-1:0] corners [4];

        rst = 1'b1;
        req_valid = 1'b0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check("reset state", 64'({req_ready, busy, rsp_valid, rsp_err, rsp_result, op_count}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, {RW{1'b0}}, 16'd0}));

        run_op("add 100-50", 2'd0, 17'd100, -17'sd50, 0);
        run_op("sub min", 2'd1, -17'sd65536, 17'd65535, 0);
        run_op("sub b=min", 2'd1, 17'd0, -17'sd65536, 0);
        run_op("mul minmin", 2'd2, -17'sd65536, -17'sd65536, 0);
        run_op("mul max*-1", 2'd2, 17'd65535, -17'sd1, 0);
        run_op("add 1+1 stall", 2'd0, 17'd1, 17'd1, 5);
        run_op("illegal", 2'd3, 17'd1234, 17'd5678, 1);
        run_op("add 7+8", 2'd0, 17'd7, 17'd8, 0);

        // Reset in the second EXEC cycle of a SUB discards it.
        req_valid = 1'b1;
        req_op = 2'd1;
        req_a = 17'd10;
        req_b = 17'd3;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_count = 0;
        check("rst in exec", 64'({req_ready, busy, op_count}), 64'({1'b1, 1'b0, 16'd0}));
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) seen++;
            tick();
        end
        check("rst no rsp", 64'(seen), 64'(0));

        corners[0] = -17'sd65536;
        corners[1] = 17'd65535;
        corners[2] = -17'sd1;
        corners[3] = 17'd0;
        for (int k = 0; k < 40; k++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : OPW'($urandom);
            r_b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : OPW'($urandom);
            run_op($sformatf("rand%0d", k), r_op, r_a, r_b, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
